// File: rtl/collision_score_unit_pkg.sv
// Shared playfield geometry and game-state encodings for the flappy datapath blocks.
package flappy_pkg;

    localparam int SCREEN_WIDTH    = 640;
    localparam int PIPE_WIDTH      = 52;
    localparam int PIPE_GAP_HEIGHT = 100;
    localparam int PIPE_DISTANCE   = 220;
    localparam int GROUND_Y        = 400;
    localparam logic signed [31:0] INVALID = -32'sd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

endpackage

// File: rtl/collision_score_unit_if.sv
// Bundle between the game core (master) and the collision/score unit (slave).
interface collision_score_unit_if;

    logic [1:0]         iState;
    logic signed [31:0] iBirdY;
    logic signed [31:0] iPipe1X;
    logic signed [31:0] iPipe2X;
    logic signed [31:0] iPipe3X;
    logic signed [31:0] iPipe1Y;
    logic signed [31:0] iPipe2Y;
    logic signed [31:0] iPipe3Y;
    logic               oCollision;
    logic               oScorePulse;
    logic [11:0]        oScore;
    logic [11:0]        oBestScore;

    modport master (
        output iState, iBirdY, iPipe1X, iPipe2X, iPipe3X, iPipe1Y, iPipe2Y, iPipe3Y,
        input  oCollision, oScorePulse, oScore, oBestScore
    );

    modport slave (
        input  iState, iBirdY, iPipe1X, iPipe2X, iPipe3X, iPipe1Y, iPipe2Y, iPipe3Y,
        output oCollision, oScorePulse, oScore, oBestScore
    );

endinterface

// File: rtl/collision_score_unit_bcd_sat_adder.sv
// Combinational 3-digit BCD adder for a 0..3 increment, clamping the result at 999.
module bcd_sat_adder (
    input  logic [11:0] i_value,
    input  logic [1:0]  i_inc,
    output logic [11:0] o_sum
);

    logic [4:0] w_s0, w_s1, w_s2;
    logic [4:0] w_a0, w_a1, w_a2;
    logic       w_c0, w_c1, w_c2;
    logic [3:0] w_d0, w_d1, w_d2;

    assign w_s0 = {1'b0, i_value[3:0]} + {3'b000, i_inc};
    assign w_c0 = (w_s0 > 5'd9);
    assign w_a0 = w_s0 - 5'd10;
    assign w_d0 = w_c0 ? w_a0[3:0] : w_s0[3:0];

    assign w_s1 = {1'b0, i_value[7:4]} + {4'b0000, w_c0};
    assign w_c1 = (w_s1 > 5'd9);
    assign w_a1 = w_s1 - 5'd10;
    assign w_d1 = w_c1 ? w_a1[3:0] : w_s1[3:0];

    assign w_s2 = {1'b0, i_value[11:8]} + {4'b0000, w_c1};
    assign w_c2 = (w_s2 > 5'd9);
    assign w_a2 = w_s2 - 5'd10;
    assign w_d2 = w_c2 ? w_a2[3:0] : w_s2[3:0];

    // A carry out of the hundreds digit means the true sum passed 999.
    assign o_sum = w_c2 ? 12'h999 : {w_d2, w_d1, w_d0};

endmodule

// File: rtl/collision_score_unit.sv
// Two-stage bird/pipe/boundary collision detector with BCD current and best score.
module collision_score_unit #(
    parameter int BIRD_X          = 160,
    parameter int BIRD_W          = 34,
    parameter int BIRD_H          = 24,
    parameter int PIPE_WIDTH      = flappy_pkg::PIPE_WIDTH,
    parameter int PIPE_GAP_HEIGHT = flappy_pkg::PIPE_GAP_HEIGHT,
    parameter int GROUND_Y        = flappy_pkg::GROUND_Y
) (
    input  logic                   iClock,
    input  logic                   iReset,
    collision_score_unit_if.slave  bus
);

    import flappy_pkg::*;

    logic               w_isIdle, w_isPlay, w_isOver;
    logic signed [31:0] w_pipeX [3];
    logic signed [31:0] w_pipeY [3];
    logic [2:0]         w_hit, w_pass, w_recycle;
    logic               w_anyHit;
    logic [1:0]         w_inc;
    logic [11:0]        w_scoreSum;

    logic               r_s1Play, r_boundary;
    logic               r_collision, r_scorePulse, r_wasOver;
    logic [2:0]         r_passed;
    logic [11:0]        r_score, r_best;

    assign w_isIdle = (state_t'(bus.iState) == IDLE);
    assign w_isPlay = (state_t'(bus.iState) == PLAY);
    assign w_isOver = bus.iState[1];

    assign w_pipeX[0] = bus.iPipe1X;
    assign w_pipeX[1] = bus.iPipe2X;
    assign w_pipeX[2] = bus.iPipe3X;
    assign w_pipeY[0] = bus.iPipe1Y;
    assign w_pipeY[1] = bus.iPipe2Y;
    assign w_pipeY[2] = bus.iPipe3Y;

    // Stage 1, per pipe: register the geometric terms; passed-flag gating happens in stage 2.
    for (genvar k = 0; k < 3; k++) begin : gPipe
        logic signed [31:0] w_pipeRight;
        logic               r_valid, r_hOverlap, r_vOutside, r_passGeom, r_recycle;

        assign w_pipeRight = w_pipeX[k] + PIPE_WIDTH;

        always_ff @(posedge iClock) begin
            if (iReset) begin
                r_valid    <= 1'b0;
                r_hOverlap <= 1'b0;
                r_vOutside <= 1'b0;
                r_passGeom <= 1'b0;
                r_recycle  <= 1'b0;
            end else begin
                r_valid    <= (w_pipeY[k] != INVALID);
                r_hOverlap <= (w_pipeX[k] < BIRD_X + BIRD_W) && (w_pipeRight > BIRD_X);
                r_vOutside <= (bus.iBirdY < w_pipeY[k]) ||
                              (bus.iBirdY + BIRD_H > w_pipeY[k] + PIPE_GAP_HEIGHT);
                r_passGeom <= (w_pipeRight <= BIRD_X);
                r_recycle  <= (w_pipeX[k] > BIRD_X + BIRD_W);
            end
        end

        assign w_hit[k]     = r_valid & r_hOverlap & r_vOutside;
        assign w_pass[k]    = r_valid & r_passGeom & ~r_passed[k];
        assign w_recycle[k] = r_recycle;
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_s1Play   <= 1'b0;
            r_boundary <= 1'b0;
        end else begin
            r_s1Play   <= w_isPlay;
            r_boundary <= (bus.iBirdY < 0) || (bus.iBirdY + BIRD_H > GROUND_Y);
        end
    end

    assign w_anyHit = (|w_hit) | r_boundary;
    assign w_inc    = 2'(w_pass[0]) + 2'(w_pass[1]) + 2'(w_pass[2]);

    bcd_sat_adder uAdder (
        .i_value (r_score),
        .i_inc   (w_inc),
        .o_sum   (w_scoreSum)
    );

    // Stage 2: results only apply when the playing state held across both stages.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_collision  <= 1'b0;
            r_scorePulse <= 1'b0;
            r_wasOver    <= 1'b0;
            r_passed     <= 3'b000;
            r_score      <= 12'h000;
            r_best       <= 12'h000;
        end else begin
            r_scorePulse <= 1'b0;
            r_wasOver    <= w_isOver;
            if (w_isIdle) begin
                r_collision <= 1'b0;
                r_passed    <= 3'b000;
                r_score     <= 12'h000;
            end else if (w_isOver) begin
                if (!r_wasOver && (r_score > r_best)) begin
                    r_best <= r_score;
                end
            end else if (r_s1Play && !r_collision) begin
                if (w_anyHit) begin
                    r_collision <= 1'b1;
                end else begin
                    r_passed     <= w_pass | (r_passed & ~w_recycle);
                    r_score      <= w_scoreSum;
                    r_scorePulse <= (w_inc != 2'd0);
                end
            end
        end
    end

    assign bus.oCollision  = r_collision;
    assign bus.oScorePulse = r_scorePulse;
    assign bus.oScore      = r_score;
    assign bus.oBestScore  = r_best;

endmodule

// File: tb/tb_collision_score_unit.sv
// Directed self-checking bench for collision_score_unit with hand-computed expectations.
module tb_collision_score_unit;

    logic iClock = 1'b0;
    logic iReset = 1'b1;
    int   total  = 0;
    int   bad    = 0;

    collision_score_unit_if busIf ();

    collision_score_unit dut (
        .iClock (iClock),
        .iReset (iReset),
        .bus    (busIf)
    );

    always #5 iClock = ~iClock;

    task automatic step(input int n);
        repeat (n) @(negedge iClock);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] state, input int birdY);
        busIf.iState = state;
        busIf.iBirdY = birdY;
    endtask

    task automatic setPipe(input int k, input int x, input int y);
        case (k)
            0: begin busIf.iPipe1X = x; busIf.iPipe1Y = y; end
            1: begin busIf.iPipe2X = x; busIf.iPipe2Y = y; end
            default: begin busIf.iPipe3X = x; busIf.iPipe3Y = y; end
        endcase
    endtask

    // Drive the first nValid pipes through the pass zone and back out to the recycle zone.
    task automatic passRound(input int nValid);
        for (int k = 0; k < 3; k++) setPipe(k, 100, (k < nValid) ? 120 : -1);
        step(2);
        for (int k = 0; k < 3; k++) setPipe(k, 300, (k < nValid) ? 120 : -1);
        step(2);
    endtask

    initial begin
        applyStimulus(2'd0, 150);
        for (int k = 0; k < 3; k++) setPipe(k, 500, -1);
        step(2);
        checkOutput("reset_collision", 32'(busIf.oCollision), 0);
        checkOutput("reset_pulse", 32'(busIf.oScorePulse), 0);
        checkOutput("reset_score", 32'(busIf.oScore), 32'h000);
        checkOutput("reset_best", 32'(busIf.oBestScore), 32'h000);
        iReset = 1'b0;

        // Clean pass through a gap at 120..219
        applyStimulus(2'd1, 150);
        step(2);
        for (int x = 200; x > 108; x -= 4) begin
            setPipe(0, x, 120);
            step(1);
            checkOutput("sweep_no_collision", 32'(busIf.oCollision), 0);
            checkOutput("sweep_score_zero", 32'(busIf.oScore), 32'h000);
        end
        setPipe(0, 108, 120);
        step(1);
        checkOutput("pass_latency1_score", 32'(busIf.oScore), 32'h000);
        step(1);
        checkOutput("pass_score_001", 32'(busIf.oScore), 32'h001);
        checkOutput("pass_pulse", 32'(busIf.oScorePulse), 1);
        step(1);
        checkOutput("pass_pulse_once", 32'(busIf.oScorePulse), 0);
        for (int x = 104; x >= 100; x -= 4) begin
            setPipe(0, x, 120);
            step(1);
        end
        step(2);
        checkOutput("pass_no_double", 32'(busIf.oScore), 32'h001);
        checkOutput("pass_no_collision", 32'(busIf.oCollision), 0);
        setPipe(0, 300, 120);
        step(2);

        // Invalid pipe overlapping the bird
        applyStimulus(2'd1, 0);
        setPipe(1, 150, -1);
        step(3);
        checkOutput("invalid_no_collision", 32'(busIf.oCollision), 0);
        checkOutput("invalid_no_score", 32'(busIf.oScore), 32'h001);
        setPipe(1, 500, -1);

        // Bird bottom exactly on the ground row
        applyStimulus(2'd1, 376);
        step(3);
        checkOutput("ground_376_ok", 32'(busIf.oCollision), 0);
        applyStimulus(2'd1, 150);

        // Best score capture
        for (int r = 0; r < 4; r++) passRound(1);
        checkOutput("play_to_005", 32'(busIf.oScore), 32'h005);
        applyStimulus(2'd2, 150);
        step(1);
        checkOutput("best_005", 32'(busIf.oBestScore), 32'h005);
        checkOutput("over_score_hold", 32'(busIf.oScore), 32'h005);
        applyStimulus(2'd0, 150);
        step(1);
        checkOutput("idle_score_clear", 32'(busIf.oScore), 32'h000);
        checkOutput("idle_best_hold", 32'(busIf.oBestScore), 32'h005);
        applyStimulus(2'd1, 150);
        step(2);
        for (int r = 0; r < 3; r++) passRound(1);
        checkOutput("play_to_003", 32'(busIf.oScore), 32'h003);
        applyStimulus(2'd2, 150);
        step(2);
        checkOutput("best_stays_005", 32'(busIf.oBestScore), 32'h005);

        // Boundary hits
        applyStimulus(2'd0, 150);
        step(1);
        applyStimulus(2'd1, 150);
        step(2);
        applyStimulus(2'd1, 377);
        step(1);
        checkOutput("ground_377_latency", 32'(busIf.oCollision), 0);
        step(1);
        checkOutput("ground_377_hit", 32'(busIf.oCollision), 1);
        applyStimulus(2'd0, 150);
        step(1);
        checkOutput("idle_clears_collision", 32'(busIf.oCollision), 0);
        applyStimulus(2'd1, 150);
        step(2);
        applyStimulus(2'd1, -1);
        step(2);
        checkOutput("ceiling_hit", 32'(busIf.oCollision), 1);
        applyStimulus(2'd0, 150);
        step(1);

        // Pipe hit, then a pass that must not score
        applyStimulus(2'd1, 150);
        step(2);
        passRound(1);
        checkOutput("prehit_score", 32'(busIf.oScore), 32'h001);
        applyStimulus(2'd1, 100);
        setPipe(0, 180, 150);
        step(2);
        checkOutput("pipe_hit", 32'(busIf.oCollision), 1);
        applyStimulus(2'd1, 150);
        setPipe(0, 100, 120);
        step(3);
        checkOutput("frozen_score", 32'(busIf.oScore), 32'h001);
        checkOutput("frozen_no_pulse", 32'(busIf.oScorePulse), 0);
        applyStimulus(2'd2, 150);
        step(2);
        checkOutput("over_collision_hold", 32'(busIf.oCollision), 1);
        checkOutput("over_best_005", 32'(busIf.oBestScore), 32'h005);

        // BCD carries and saturation
        applyStimulus(2'd0, 150);
        setPipe(0, 300, 120);
        step(1);
        applyStimulus(2'd1, 150);
        step(2);
        for (int r = 0; r < 33; r++) passRound(3);
        checkOutput("score_099", 32'(busIf.oScore), 32'h099);
        passRound(1);
        checkOutput("score_100", 32'(busIf.oScore), 32'h100);
        for (int r = 0; r < 299; r++) passRound(3);
        checkOutput("score_997", 32'(busIf.oScore), 32'h997);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) setPipe(k, 100, 120);
            step(2);
            checkOutput("sat_score_999", 32'(busIf.oScore), 32'h999);
            checkOutput("sat_pulse", 32'(busIf.oScorePulse), 1);
            for (int k = 0; k < 3; k++) setPipe(k, 300, 120);
            step(2);
        end
        applyStimulus(2'd2, 150);
        step(1);
        checkOutput("best_999", 32'(busIf.oBestScore), 32'h999);

        // Reset returns everything, including best, to zero
        iReset = 1'b1;
        step(1);
        checkOutput("rst_best", 32'(busIf.oBestScore), 32'h000);
        checkOutput("rst_score", 32'(busIf.oScore), 32'h000);
        checkOutput("rst_collision", 32'(busIf.oCollision), 0);
        iReset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
